// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_port_arbiter
// Purpose  : Two-port round-robin arbiter and WRITE/READ command sequencer in
//            front of the ddr_sdram driver. Optional watchdog enabled by
//            defining DDR_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_port_arbiter #(
  parameter int WRITE_LENGTH   = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        SYS_CLK_100M,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        REQ_WR0,
  input  logic        REQ_WR1,
  input  logic [1:0]  REQ_BA0,
  input  logic [1:0]  REQ_BA1,
  input  logic [12:0] REQ_ROW0,
  input  logic [12:0] REQ_ROW1,
  input  logic [9:0]  REQ_COL0,
  input  logic [9:0]  REQ_COL1,
  input  logic [15:0] REQ_WDATA0,
  input  logic [15:0] REQ_WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [15:0] RDATA,
  output logic        DDR_WRITE,
  output logic        DDR_READ,
  output logic [1:0]  DDR_BA_IN,
  output logic [12:0] DDR_ADDR_ROW_IN,
  output logic [9:0]  DDR_ADDR_COL_IN,
  output logic [3:0]  DDR_WRITE_LENGTH,
  output logic [15:0] DDR_WDATA,
  output logic        DDR_WDATA_OE,
  input  logic [15:0] DDR_RDATA,
  input  logic        DDR_EXT_DQS,
  input  logic        DDR_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_owner;
  logic        r_wr;
  logic        r_dqs_q;
  logic [1:0]  r_ba;
  logic [12:0] r_row;
  logic [9:0]  r_col;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        w_win;
  logic        w_grant;
  logic        w_in_wait;
  logic        w_timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ddr_port_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  // Contention goes to the port that did not win last; a lone request wins.
  assign w_win     = (REQ0 && REQ1) ? ~r_last : REQ1;
  assign w_grant   = (r_state == S_IDLE) && (REQ0 || REQ1) && !DDR_BUSY;
  assign w_in_wait = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_wdog;
  logic             r_err;

  always_ff @(posedge SYS_CLK_100M) begin
    if (RST) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else if (w_grant) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else if (w_in_wait) begin
      r_wdog <= r_wdog + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th cycle spent waiting on the driver.
  assign w_timeout = w_in_wait && (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ERR0      = (r_state == S_RESP) && r_err && !r_owner;
  assign ERR1      = (r_state == S_RESP) && r_err &&  r_owner;
`else
  assign w_timeout = 1'b0;
  assign ERR0      = 1'b0;
  assign ERR1      = 1'b0;
`endif

  always_ff @(posedge SYS_CLK_100M) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_grant) w_next = S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_timeout)     w_next = S_RESP;
        else if (DDR_BUSY) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_timeout || !DDR_BUSY) w_next = S_RESP;
      end
      S_RESP:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK_100M) begin
    if (RST) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_wr    <= 1'b0;
      r_ba    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_dqs_q <= 1'b0;
    end else begin
      r_dqs_q <= DDR_EXT_DQS;
      if (w_grant) begin
        r_last  <= w_win;
        r_owner <= w_win;
        r_wr    <= w_win ? REQ_WR1    : REQ_WR0;
        r_ba    <= w_win ? REQ_BA1    : REQ_BA0;
        r_row   <= w_win ? REQ_ROW1   : REQ_ROW0;
        r_col   <= w_win ? REQ_COL1   : REQ_COL0;
        r_wdata <= w_win ? REQ_WDATA1 : REQ_WDATA0;
        r_rdata <= '0;
      end else if (w_in_wait && !r_wr && DDR_EXT_DQS && !r_dqs_q) begin
        // Each DQS rising edge overwrites, so the final beat of a burst remains.
        r_rdata <= DDR_RDATA;
      end
    end
  end

  assign GNT0             = (r_state == S_ISSUE) && !r_owner;
  assign GNT1             = (r_state == S_ISSUE) &&  r_owner;
  assign DONE0            = (r_state == S_RESP)  && !r_owner;
  assign DONE1            = (r_state == S_RESP)  &&  r_owner;
  assign DDR_WRITE        = (r_state == S_ISSUE) &&  r_wr;
  assign DDR_READ         = (r_state == S_ISSUE) && !r_wr;
  assign DDR_WDATA_OE     = r_wr && ((r_state == S_ISSUE) || w_in_wait);
  assign DDR_BA_IN        = r_ba;
  assign DDR_ADDR_ROW_IN  = r_row;
  assign DDR_ADDR_COL_IN  = r_col;
  assign DDR_WDATA        = r_wdata;
  assign DDR_WRITE_LENGTH = 4'(WRITE_LENGTH);
  assign RDATA            = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_port_arbiter
// Purpose  : Self-checking bench for ddr_port_arbiter (default build and
//            DDR_ARB_TIMEOUT_EN build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_port_arbiter;

  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [1:0]  ba0 = '0, ba1 = '0;
  logic [12:0] row0 = '0, row1 = '0;
  logic [9:0]  col0 = '0, col1 = '0;
  logic [15:0] wd0 = '0, wd1 = '0;
  logic [15:0] rdata_in = '0;
  logic        dqs = 1'b0, busy = 1'b0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic        ddr_write, ddr_read, oe;
  logic [15:0] rdata, wdata;
  logic [1:0]  ba;
  logic [12:0] row;
  logic [9:0]  col;
  logic [3:0]  wlen;

  ddr_port_arbiter #(.WRITE_LENGTH(1), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .SYS_CLK_100M(clk), .RST(rst),
    .REQ0(req0), .REQ1(req1), .REQ_WR0(wr0), .REQ_WR1(wr1),
    .REQ_BA0(ba0), .REQ_BA1(ba1), .REQ_ROW0(row0), .REQ_ROW1(row1),
    .REQ_COL0(col0), .REQ_COL1(col1), .REQ_WDATA0(wd0), .REQ_WDATA1(wd1),
    .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
    .ERR0(err0), .ERR1(err1), .RDATA(rdata),
    .DDR_WRITE(ddr_write), .DDR_READ(ddr_read), .DDR_BA_IN(ba),
    .DDR_ADDR_ROW_IN(row), .DDR_ADDR_COL_IN(col), .DDR_WRITE_LENGTH(wlen),
    .DDR_WDATA(wdata), .DDR_WDATA_OE(oe), .DDR_RDATA(rdata_in),
    .DDR_EXT_DQS(dqs), .DDR_BUSY(busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          model_last;            // port granted most recently
  logic        f_wr  [2];
  logic [1:0]  f_ba  [2];
  logic [12:0] f_row [2];
  logic [9:0]  f_col [2];
  logic [15:0] f_wd  [2];
  logic [15:0] g_d0, g_d1;            // read beats returned by the driver model

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    for (int p = 0; p < 2; p++) begin
      f_wr[p]  = 1'($urandom);
      f_ba[p]  = 2'($urandom);
      f_row[p] = 13'($urandom);
      f_col[p] = 10'($urandom);
      f_wd[p]  = 16'($urandom);
    end
    g_d0 = 16'($urandom);
    g_d1 = 16'($urandom);
  endtask

  task automatic apply_req(input bit r0, input bit r1);
    req0 = r0; req1 = r1;
    wr0 = f_wr[0]; ba0 = f_ba[0]; row0 = f_row[0]; col0 = f_col[0]; wd0 = f_wd[0];
    wr1 = f_wr[1]; ba1 = f_ba[1]; row1 = f_row[1]; col1 = f_col[1]; wd1 = f_wd[1];
  endtask

  // Round-robin rule: sole requester wins, otherwise the port not served last.
  function automatic bit pick(input bit r0, input bit r1);
    if (r0 && r1) return !model_last;
    return r1;
  endfunction

  // One full transaction: optional BUSY hold-off, grant, driver busy window
  // with two DQS beats (second one held high for two cycles), completion.
  task automatic txn(input bit r0, input bit r1, input int hold, input int pre, input int blen);
    bit w;
    int early;
    int oe_bad;
    w = pick(r0, r1);
    model_last = w;
    apply_req(r0, r1);
    busy  = (hold > 0);
    early = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (gnt0 || gnt1) early++;
    end
    busy = 1'b0;
    tick();
    if (hold > 0) check("holdoff_no_gnt", early, 0);
    check("gnt_owner", {gnt1, gnt0}, w ? 2'b10 : 2'b01);
    check("cmd_strobe", {ddr_write, ddr_read}, f_wr[w] ? 2'b10 : 2'b01);
    check("cmd_addr", {ba, row, col}, {f_ba[w], f_row[w], f_col[w]});
    check("cmd_wdata", wdata, f_wd[w]);
    check("oe_issue", oe, f_wr[w]);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("strobe_off", {gnt1, gnt0, ddr_write, ddr_read}, 0);
    early  = 0;
    oe_bad = 0;
    for (int i = 0; i < pre; i++) begin
      tick();
      if (done0 || done1) early++;
    end
    busy = 1'b1;
    for (int i = 0; i < blen; i++) begin
      dqs      = (i == 1) || (i == 3) || (i == 4);
      rdata_in = (i == 1) ? g_d0 : (i == 3) ? g_d1 : 16'($urandom);
      tick();
      if (done0 || done1) early++;
      if (oe !== f_wr[w]) oe_bad++;
    end
    busy = 1'b0;
    dqs  = 1'b0;
    tick();
    check("no_early_done", early, 0);
    check("oe_wait", oe_bad, 0);
    check("done_owner", {done1, done0}, w ? 2'b10 : 2'b01);
    check("err_normal", {err1, err0}, 0);
    check("rdata", rdata, f_wr[w] ? 16'h0 : g_d1);
    check("oe_resp", oe, 0);
    check("addr_hold", {ba, row, col}, {f_ba[w], f_row[w], f_col[w]});
    tick();
    check("done_clear", {done1, done0}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gq[$];
    int   both;
    int   bcnt;
    int   early;
    logic m0, m1;

    // ---- reset state, with both requests already asserted ----
    rand_fields();
    apply_req(1'b1, 1'b1);
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ctrl", {gnt0, gnt1, done0, done1, err0, err1, ddr_write, ddr_read, oe}, 0);
    check("rst_data", {ba, row, col, wdata, rdata}, 0);
    check("write_length", wlen, 4'd1);
    model_last = 1'b1;

    // ---- both requests held high continuously: grants alternate 0,1,0,1 ----
    rst  = 1'b0;
    both = 0;
    bcnt = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc == 80) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      if (gnt0 && gnt1) both++;
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
      if (ddr_write || ddr_read) bcnt = 4;
      busy = (bcnt > 0);
      if (bcnt > 0) bcnt--;
    end
    busy = 1'b0;
    repeat (3) tick();
    check("alt_no_double_gnt", both, 0);
    check("alt_grant_count_ge8", (gq.size() >= 8) ? 1 : 0, 1);
    foreach (gq[i]) check($sformatf("alt_grant_%0d", i), gq[i], i % 2);
    if (gq.size() > 0) model_last = gq[gq.size() - 1][0];

    // ---- directed write on port 0, BUSY high for 4 cycles ----
    rand_fields();
    f_wr[0] = 1'b1; f_ba[0] = 2'd1; f_row[0] = 13'h0123; f_col[0] = 10'h045; f_wd[0] = 16'hA5C3;
    txn(1'b1, 1'b0, 0, 0, 4);

    // ---- directed read on port 1, beats 0x1111 then 0xBEEF ----
    rand_fields();
    f_wr[1] = 1'b0;
    g_d0 = 16'h1111; g_d1 = 16'hBEEF;
    txn(1'b0, 1'b1, 0, 1, 6);

    // ---- request while driver still busy in IDLE ----
    rand_fields();
    txn(1'b1, 1'b0, 3, 0, 5);

    // ---- randomized traffic ----
    for (int k = 0; k < 8; k++) begin
      int m;
      rand_fields();
      m = $urandom_range(1, 3);
      txn(m[0], m[1], $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(5, 11));
    end

    // ---- reset during WAIT_DONE of a port-0 read with data captured ----
    rand_fields();
    f_wr[0] = 1'b0;
    model_last = 1'b0;
    apply_req(1'b1, 1'b0);
    tick();
    check("rstmid_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    busy = 1'b1;
    tick();
    tick();
    dqs = 1'b1; rdata_in = 16'hDEAD;
    tick();
    dqs = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_ctrl", {gnt0, gnt1, done0, done1, err0, err1, ddr_write, ddr_read, oe}, 0);
    check("rstmid_data", {ba, row, col, wdata, rdata}, 0);
    rst  = 1'b0;
    busy = 1'b0;
    model_last = 1'b1;
    early = 0;
    repeat (4) begin
      tick();
      if (done0 || done1 || gnt0 || gnt1) early++;
    end
    check("rstmid_no_done", early, 0);
    rand_fields();
    txn(1'b1, 1'b1, 0, 0, 5);

    // ---- BUSY stuck high ----
    rand_fields();
    f_wr[0] = 1'b1;
    model_last = 1'b0;
    apply_req(1'b1, 1'b0);
    tick();
    check("stuck_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    busy = 1'b1;
    tick();
    early = 0;
`ifdef DDR_ARB_TIMEOUT_EN
    for (int i = 0; i < TO_CYC - 1; i++) begin
      tick();
      if (done0 || done1 || err0 || err1) early++;
    end
    tick();
    check("to_no_early", early, 0);
    check("to_done", {done1, done0}, 2'b01);
    check("to_err", {err1, err0}, 2'b01);
    tick();
    check("to_clear", {done1, done0, err1, err0}, 0);
    busy = 1'b0;
    tick();
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done0 || done1 || err0 || err1) early++;
    end
    check("stuck_no_done", early, 0);
    busy = 1'b0;
    tick();
    check("stuck_release_done", {done1, done0}, 2'b01);
    check("stuck_release_err", {err1, err0}, 0);
    tick();
`endif
    m0 = done0; m1 = done1;
    check("final_idle", {m1, m0, gnt1, gnt0}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
